// File: rtl/mem_port_arbiter_if.sv
// Signal bundle of the shared data-memory port: IF/MEM requester handshakes and RAM side.
// master = requesters plus memory array; slave = the arbiter.
interface mem_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_err;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_err;

   logic              busy;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_err,
      output if_gnt, if_rvalid, if_rdata, if_err,
      output mem_gnt, mem_rvalid, mem_rdata, mem_err,
      output ram_en, ram_we, ram_addr, ram_wdata, busy
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_err,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
      input  ram_en, ram_we, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF (read) and MEM (read/write); grant in the request cycle,
// response MEM_LAT cycles later; requests are held by the requester until gnt, one access in flight.
module mem_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int MEM_BYTES  = 4096,
   parameter int MEM_LAT    = 2,
   parameter int MAX_STREAK = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int ST_W  = $clog2(MAX_STREAK + 1);
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ST_W-1:0]   r_streak;
   logic              r_own_if;
   logic              r_we;
   logic              r_chk_err;

   logic              w_idle;
   logic              w_wait;
   logic              w_pick_if;
   logic              w_grant;
   logic [ADDR_W-1:0] w_addr;
   logic              w_we;
   logic              w_bad;
   logic              w_ram_go;
   logic              w_resp;
   logic [DATA_W-1:0] w_rdata;
   logic              w_err;

   // Outputs are gated by RST_N so nothing leaks out (and no request is released) during reset.
   assign w_idle    = RST_N && (r_state == S_IDLE);
   assign w_wait    = RST_N && (r_state == S_WAIT);
   assign w_pick_if = bus.if_req && (!bus.mem_req || (r_streak == ST_W'(MAX_STREAK)));
   assign w_grant   = w_idle && (bus.if_req || bus.mem_req);
   assign w_addr    = w_pick_if ? bus.if_addr : bus.mem_addr;
   assign w_we      = !w_pick_if && bus.mem_we;
   assign w_bad     = (w_addr[1:0] != 2'b00) || (w_addr >= ADDR_LIMIT);
   assign w_ram_go  = w_grant && !w_bad;
   assign w_resp    = w_wait && (r_cnt == '0);

   assign bus.if_gnt    = w_grant && w_pick_if;
   assign bus.mem_gnt   = w_grant && !w_pick_if;
   assign bus.ram_en    = w_ram_go;
   assign bus.ram_we    = w_ram_go && w_we;
   assign bus.ram_addr  = w_ram_go ? w_addr : '0;
   assign bus.ram_wdata = (w_ram_go && w_we) ? bus.mem_wdata : '0;
   assign bus.busy      = w_grant || w_wait;

   // A check error never issued ram_en, so ram_err can only add to it when the access really ran.
   assign w_rdata = (r_we || r_chk_err) ? '0 : bus.ram_rdata;
   assign w_err   = r_chk_err || bus.ram_err;

   assign bus.if_rvalid  = w_resp && r_own_if;
   assign bus.if_rdata   = (w_resp && r_own_if) ? w_rdata : '0;
   assign bus.if_err     = w_resp && r_own_if && w_err;
   assign bus.mem_rvalid = w_resp && !r_own_if;
   assign bus.mem_rdata  = (w_resp && !r_own_if) ? w_rdata : '0;
   assign bus.mem_err    = w_resp && !r_own_if && w_err;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_streak  <= '0;
         r_own_if  <= 1'b0;
         r_we      <= 1'b0;
         r_chk_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_state   <= S_WAIT;
                  r_cnt     <= CNT_W'(MEM_LAT - 1);
                  r_own_if  <= w_pick_if;
                  r_we      <= w_we;
                  r_chk_err <= w_bad;
                  // Streak only grows while IF is actually being held off.
                  if (w_pick_if || !bus.if_req) begin
                     r_streak <= '0;
                  end else if (r_streak != ST_W'(MAX_STREAK)) begin
                     r_streak <= r_streak + ST_W'(1);
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
